uart_tx_engine: RTL and testbench

- Read-side consumer of the team's DATA_WIDTH/FIFO_DEPTH transmit FIFO.
- Pops one word whenever the FIFO is non-empty and transmission is enabled, then serializes it onto a UART line.
- Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Drives the FIFO's read_en and consumes its registered read_data, which is valid one cycle after the pop.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_cnt.sv | 33 +++
 rtl/uart_tx_engine.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_e;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned BIT_IDX_W      = $clog2(DATA_WIDTH_DEF + 1);
  localparam logic        IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Reloadable baud down-counter: tick marks the last cycle of a bit, pre_tick the one before it.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o,
  output logic                 pre_tick_o
);

  logic [DIV_WIDTH-1:0] cnt_r;

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
    end else if (load_i) begin
      cnt_r <= div_i;
    end else if (cnt_r != {DIV_WIDTH{1'b0}}) begin
      cnt_r <= cnt_r - DIV_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick_o     = (cnt_r == {DIV_WIDTH{1'b0}});
  assign pre_tick_o = (cnt_r == DIV_WIDTH'(1));

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter that pops words from a registered-read FIFO and serializes them
// as start, LSB-first data, optional parity and one or two stop bits.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  tx_en_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int IDX_W = (DATA_WIDTH == int'(DATA_WIDTH_DEF)) ? int'(BIT_IDX_W)
                                                               : $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  tx_state_e             state_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DIV_WIDTH-1:0]  div_r;
  logic                  par_en_r;
  logic                  stop2_r;
  logic                  parity_r;
  logic [IDX_W-1:0]      bit_idx_r;
  logic                  stop_idx_r;
  logic                  tx_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  rd_en_s;
  logic                  tick_s;
  logic                  pre_tick_s;
  logic                  bit_end_s;
  logic                  load_s;
  logic [DIV_WIDTH-1:0]  div_sel_s;
  logic                  div_zero_s;
  logic                  last_stop_s;
  logic [DATA_WIDTH-1:0] shift_nx_s;
  logic                  done_nx_s;

  assign rd_en_s = (state_r == IDLE) & tx_en_i & ~fifo_empty_i;

  // Bit-boundary decode, counter reload control and look-ahead for the done pulse.
  always_comb begin
    bit_end_s   = 1'b0;
    done_nx_s   = 1'b0;
    div_zero_s  = (div_r == {DIV_WIDTH{1'b0}});
    last_stop_s = ~stop2_r | stop_idx_r;
    shift_nx_s  = shift_r >> 1;
    case (state_r)
      START, DATA, PARITY: bit_end_s = tick_s;
      STOP:                bit_end_s = tick_s;
      default:             bit_end_s = 1'b0;
    endcase
    if (state_r == FETCH) begin
      load_s    = 1'b1;
      div_sel_s = baud_div_i;
    end else begin
      load_s    = bit_end_s;
      div_sel_s = div_r;
    end
    // done is registered, so it is raised one cycle ahead of the final stop cycle
    case (state_r)
      DATA:    done_nx_s = bit_end_s & (bit_idx_r == LAST_IDX) & ~par_en_r & ~stop2_r & div_zero_s;
      PARITY:  done_nx_s = bit_end_s & ~stop2_r & div_zero_s;
      STOP: begin
        if (bit_end_s) begin
          done_nx_s = stop2_r & ~stop_idx_r & div_zero_s;
        end else begin
          done_nx_s = last_stop_s & pre_tick_s;
        end
      end
      default: done_nx_s = 1'b0;
    endcase
  end

  uart_baud_cnt #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_cnt (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .load_i     (load_s),
    .div_i      (div_sel_s),
    .tick_o     (tick_s),
    .pre_tick_o (pre_tick_s)
  );

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      shift_r    <= {DATA_WIDTH{1'b0}};
      div_r      <= {DIV_WIDTH{1'b0}};
      par_en_r   <= 1'b0;
      stop2_r    <= 1'b0;
      parity_r   <= 1'b0;
      bit_idx_r  <= {IDX_W{1'b0}};
      stop_idx_r <= 1'b0;
      tx_r       <= IDLE_LEVEL;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= done_nx_s;
      case (state_r)
        IDLE: begin
          tx_r <= IDLE_LEVEL;
          if (rd_en_s) begin
            state_r <= FETCH;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        FETCH: begin
          shift_r    <= fifo_rd_data_i;
          div_r      <= baud_div_i;
          par_en_r   <= parity_en_i;
          stop2_r    <= stop2_i;
          parity_r   <= calc_parity(fifo_rd_data_i, parity_odd_i);
          bit_idx_r  <= {IDX_W{1'b0}};
          stop_idx_r <= 1'b0;
          tx_r       <= 1'b0;
          state_r    <= START;
        end
        START: begin
          if (bit_end_s) begin
            tx_r    <= shift_r[0];
            state_r <= DATA;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            shift_r <= shift_nx_s;
            if (bit_idx_r == LAST_IDX) begin
              bit_idx_r <= {IDX_W{1'b0}};
              tx_r      <= par_en_r ? parity_r : IDLE_LEVEL;
              state_r   <= par_en_r ? PARITY : STOP;
            end else begin
              bit_idx_r <= bit_idx_r + IDX_W'(1);
              tx_r      <= shift_nx_s[0];
            end
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            tx_r    <= IDLE_LEVEL;
            state_r <= STOP;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            if (last_stop_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              stop_idx_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= IDLE_LEVEL;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en_o = rd_en_s;
  assign tx_o         = tx_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine with a small registered-read FIFO model.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        tx;
  logic        busy;
  logic        done;

  int tests = 0;
  int failed = 0;

  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int bad_pops = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk            (clk),
    .rst_ni         (rst_ni),
    .tx_en_i        (tx_en),
    .baud_div_i     (baud_div),
    .parity_en_i    (parity_en),
    .parity_odd_i   (parity_odd),
    .stop2_i        (stop2),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_rd_data_i (fifo_rd_data),
    .tx_o           (tx),
    .busy_o         (busy),
    .done_o         (done)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
      pops         <= pops + 1;
      if (fifo_empty) bad_pops <= bad_pops + 1;
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    logic        exp_par;
    int          exp_len;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Send one table vector; scramble configuration after the frame has started.
  task automatic run_frame(input int v);
    logic bits [0:11];
    int   n, busy_cnt, done_cnt, rd_busy, idx;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = vecs[v].data[i];
    n = 9;
    if (vecs[v].par_en) begin bits[n] = vecs[v].exp_par; n++; end
    bits[n] = 1'b1; n++;
    if (vecs[v].stop2) begin bits[n] = 1'b1; n++; end
    baud_div   = vecs[v].div;
    parity_en  = vecs[v].par_en;
    parity_odd = vecs[v].par_odd;
    stop2      = vecs[v].stop2;
    tx_en      = 1'b1;
    push(vecs[v].data);
    #1;
    check($sformatf("v%0d_pop", v), fifo_rd_en, 1'b1);
    busy_cnt = 0; done_cnt = 0; rd_busy = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (fifo_rd_en !== 1'b0) rd_busy++;
      if (cyc == 0) begin
        check($sformatf("v%0d_fetch_tx", v), tx, 1'b1);
      end else begin
        idx = (cyc - 1) / (int'(vecs[v].div) + 1);
        if (idx < n) check($sformatf("v%0d_tx_c%0d", v, cyc), tx, bits[idx]);
        check($sformatf("v%0d_done_c%0d", v, cyc), done, (cyc == vecs[v].exp_len));
      end
      if (cyc == 1) begin
        baud_div   = vecs[v].div + 16'd5;
        parity_en  = ~vecs[v].par_en;
        parity_odd = ~vecs[v].par_odd;
        stop2      = ~vecs[v].stop2;
      end
    end
    check($sformatf("v%0d_busy_len", v), busy_cnt, vecs[v].exp_len + 1);
    check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
    check($sformatf("v%0d_rd_in_frame", v), rd_busy, 0);
    check($sformatf("v%0d_idle_tx", v), tx, 1'b1);
  endtask

  logic tx_tr [0:59];
  logic busy_tr [0:59];
  logic done_tr [0:59];
  logic rd_tr [0:59];

  initial begin
    int p0, bad_rd, bad_tx, bad_busy, low_cnt, done_cnt, start2, run;
    vecs[0] = '{8'hA5, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 40};
    vecs[1] = '{8'h07, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1, 22};
    vecs[2] = '{8'h07, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, 22};
    vecs[3] = '{8'h07, 16'd2, 1'b1, 1'b0, 1'b1, 1'b1, 36};
    vecs[4] = '{8'hFF, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10};
    vecs[5] = '{8'h00, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 12};
    vecs[6] = '{8'h3C, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 33};

    rst_ni = 1'b0; tx_en = 1'b0; baud_div = 16'd0;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    rst_ni = 1'b1;

    // Enabled with an empty FIFO: nothing may happen.
    tx_en = 1'b1;
    bad_rd = 0; bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0) bad_rd++;
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    check("empty_rd_en", bad_rd, 0);
    check("empty_tx", bad_tx, 0);
    check("empty_busy", bad_busy, 0);

    for (int v = 0; v < 7; v++) run_frame(v);

    // Back-to-back frames from two preloaded words.
    baud_div = 16'd1; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; tx_en = 1'b1;
    p0 = pops;
    push(8'h11); push(8'h22);
    #1;
    for (int t = 0; t < 60; t++) begin
      if (t > 0) @(negedge clk);
      tx_tr[t] = tx; busy_tr[t] = busy; done_tr[t] = done; rd_tr[t] = fifo_rd_en;
    end
    low_cnt = 0; done_cnt = 0; start2 = -1;
    for (int t = 1; t <= 40; t++) if (busy_tr[t] !== 1'b1) low_cnt++;
    for (int t = 0; t < 60; t++) if (done_tr[t] === 1'b1) done_cnt++;
    for (int t = 59; t > 21; t--) if (tx_tr[t] === 1'b0) start2 = t;
    run = 0;
    if (start2 > 0) for (int t = start2 - 1; t > 0 && tx_tr[t] === 1'b1; t--) run++;
    check("b2b_pops", pops - p0, 2);
    check("b2b_busy_gap", low_cnt, 1);
    check("b2b_second_pop", rd_tr[22], 1'b1);
    check("b2b_done_first", done_tr[21], 1'b1);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_start2", start2, 24);
    check("b2b_high_gap", run, 4);

    // tx_en dropped mid-frame: frame completes, next word waits.
    baud_div = 16'd0; tx_en = 1'b1;
    p0 = pops;
    push(8'h5A); push(8'h99);
    @(negedge clk);
    tx_en = 1'b0;
    repeat (30) @(negedge clk);
    check("txen_off_pops", pops - p0, 1);
    check("txen_off_busy", busy, 1'b0);
    check("txen_off_rd_en", fifo_rd_en, 1'b0);
    tx_en = 1'b1;
    repeat (20) @(negedge clk);
    check("txen_on_pops", pops - p0, 2);
    check("txen_on_busy", busy, 1'b0);

    // Asynchronous reset in the middle of DATA.
    baud_div = 16'd3; parity_en = 1'b0; stop2 = 1'b0; tx_en = 1'b1;
    push(8'hC3);
    repeat (15) @(negedge clk);
    check("mid_tx_before_rst", tx, 1'b0);
    check("mid_busy_before_rst", busy, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    run_frame(4);
    run_frame(0);

    check("rd_en_while_empty", bad_pops, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
